// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control FSM with memory wait-state timeout and sticky trap.
// Optional performance counters are enabled with `define MC_CTRL_PERF_EN.
module mc_controller #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zero,
    input  logic             lt_s,
    input  logic             lt_u,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic [1:0]       mem_size,
    output logic             mem_unsigned,
    output logic             pc_en,
    output logic             adr_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_EX_ADR, S_MEM_RD, S_MEM_WR, S_WB_ALU,
        S_WB_MEM, S_EX_BR, S_LINK, S_JUMP, S_WB_LUI, S_EX_AUIPC, S_TRAP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       adr_src;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic       jump;
    } ctl_t;

    localparam ctl_t FETCH_CTL = ctl_t'({1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
                                         4'd0, 2'b01, 3'd0, 1'b0});
    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_t        r_state;
    state_t        w_next;
    ctl_t          r_ctl;
    ctl_t          w_ctl;
    logic [WW-1:0] r_wait;
    logic          r_trap;
    logic [1:0]    r_cause;
    logic [1:0]    w_cause;
    logic [3:0]    w_alu_op;
    logic          w_f7_alt;
    logic          w_alu_bad;
    logic          w_br_bad;
    logic          w_taken;
    logic          w_ld_ok;
    logic          w_st_ok;
    logic          w_mem_st;
    logic          w_timeout;
    logic          w_fetch_rdy;

    // Instruction-field qualifiers: ALU operation, legality and branch outcome
    always_comb begin
        w_f7_alt  = func7 == 7'b0100000;
        w_alu_bad = (op[5] || func3 == 3'b001 || func3 == 3'b101) && func7 != 7'd0 &&
                    !(w_f7_alt && (func3 == 3'b101 || (op[5] && func3 == 3'b000)));
        case (func3)
            3'b000:  w_alu_op = (op[5] && w_f7_alt) ? 4'd1 : 4'd0;
            3'b001:  w_alu_op = 4'd7;
            3'b010:  w_alu_op = 4'd4;
            3'b011:  w_alu_op = 4'd5;
            3'b100:  w_alu_op = 4'd6;
            3'b101:  w_alu_op = w_f7_alt ? 4'd9 : 4'd8;
            3'b110:  w_alu_op = 4'd3;
            default: w_alu_op = 4'd2;
        endcase
        w_br_bad  = func3[2:1] == 2'b01;
        w_taken   = (func3[2] ? (func3[1] ? lt_u : lt_s) : zero) ^ func3[0];
        w_ld_ok   = !(func3 == 3'b011 || func3[2:1] == 2'b11);
        w_st_ok   = !func3[2] && func3[1:0] != 2'b11;
        w_mem_st  = r_state == S_FETCH || r_state == S_MEM_RD || r_state == S_MEM_WR;
        w_timeout = (WAIT_MAX != 0) && (int'(r_wait) == WAIT_MAX - 1);
        w_cause   = w_mem_st ? 2'b10 : 2'b01;
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : w_timeout ? S_TRAP : S_FETCH;
            S_DECODE: begin
                case (op)
                    7'b0110011:             w_next = S_EX_R;
                    7'b0010011:             w_next = S_EX_I;
                    7'b0000011, 7'b0100011: w_next = S_EX_ADR;
                    7'b1100011:             w_next = S_EX_BR;
                    7'b1101111, 7'b1100111: w_next = S_LINK;
                    7'b0110111:             w_next = S_WB_LUI;
                    7'b0010111:             w_next = S_EX_AUIPC;
                    default:                w_next = S_TRAP;
                endcase
            end
            S_EX_R, S_EX_I: w_next = w_alu_bad ? S_TRAP : S_WB_ALU;
            S_EX_ADR:   w_next = op[5] ? (w_st_ok ? S_MEM_WR : S_TRAP) : (w_ld_ok ? S_MEM_RD : S_TRAP);
            S_MEM_RD:   w_next = mem_ready ? S_WB_MEM : w_timeout ? S_TRAP : S_MEM_RD;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : w_timeout ? S_TRAP : S_MEM_WR;
            S_EX_BR:    w_next = w_br_bad ? S_TRAP : S_FETCH;
            S_LINK:     w_next = S_JUMP;
            S_EX_AUIPC: w_next = S_WB_ALU;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    // Moore control word for the state being entered, registered below
    always_comb begin
        w_ctl = '0;
        case (w_next)
            S_FETCH:    w_ctl = FETCH_CTL;
            S_DECODE: begin
                w_ctl.alu_src_a = 2'b01;
                w_ctl.alu_src_b = 2'b01;
                w_ctl.imm_src   = 3'd2;
            end
            S_EX_R: begin
                w_ctl.alu_src_a = 2'b10;
                w_ctl.alu_op    = w_alu_op;
            end
            S_EX_I: begin
                w_ctl.alu_src_a = 2'b10;
                w_ctl.alu_src_b = 2'b01;
                w_ctl.alu_op    = w_alu_op;
            end
            S_EX_ADR: begin
                w_ctl.alu_src_a = 2'b10;
                w_ctl.alu_src_b = 2'b01;
                w_ctl.imm_src   = {2'b00, op[5]};
            end
            S_MEM_RD: begin
                w_ctl.mem_req      = 1'b1;
                w_ctl.adr_src      = 1'b1;
                w_ctl.mem_size     = func3[1:0];
                w_ctl.mem_unsigned = func3[2];
            end
            S_MEM_WR: begin
                w_ctl.mem_req   = 1'b1;
                w_ctl.mem_write = 1'b1;
                w_ctl.adr_src   = 1'b1;
                w_ctl.mem_size  = func3[1:0];
            end
            S_WB_ALU:   w_ctl.reg_write = 1'b1;
            S_WB_MEM: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.result_src = 2'b10;
            end
            S_EX_BR: begin
                w_ctl.alu_src_a = 2'b10;
                w_ctl.alu_op    = 4'd1;
            end
            S_LINK: begin
                w_ctl.alu_src_a  = 2'b01;
                w_ctl.alu_src_b  = 2'b10;
                w_ctl.result_src = 2'b01;
                w_ctl.reg_write  = 1'b1;
            end
            S_JUMP: begin
                w_ctl.alu_src_a  = op[3] ? 2'b01 : 2'b10;
                w_ctl.alu_src_b  = 2'b01;
                w_ctl.imm_src    = op[3] ? 3'd3 : 3'd0;
                w_ctl.result_src = 2'b01;
                w_ctl.jump       = 1'b1;
            end
            S_WB_LUI: begin
                w_ctl.imm_src    = 3'd4;
                w_ctl.result_src = 2'b11;
                w_ctl.reg_write  = 1'b1;
            end
            S_EX_AUIPC: begin
                w_ctl.alu_src_a = 2'b01;
                w_ctl.alu_src_b = 2'b01;
                w_ctl.imm_src   = 3'd4;
            end
            default:    w_ctl = '0;
        endcase
    end

    // State, registered controls, wait-state counter and sticky trap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ctl   <= FETCH_CTL;
            r_wait  <= '0;
            r_trap  <= 1'b0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            r_ctl   <= w_ctl;
            r_wait  <= (w_next == r_state && w_mem_st) ? r_wait + 1'b1 : '0;
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    assign w_fetch_rdy  = r_state == S_FETCH && mem_ready && rst_n;
    assign mem_req      = r_ctl.mem_req & rst_n;
    assign mem_write    = r_ctl.mem_write;
    assign mem_size     = r_ctl.mem_size;
    assign mem_unsigned = r_ctl.mem_unsigned;
    assign adr_src      = r_ctl.adr_src;
    assign reg_write    = r_ctl.reg_write;
    assign alu_src_a    = r_ctl.alu_src_a;
    assign alu_src_b    = r_ctl.alu_src_b;
    assign alu_op       = r_ctl.alu_op;
    assign result_src   = r_ctl.result_src;
    assign imm_src      = r_ctl.imm_src;
    assign ir_write     = w_fetch_rdy;
    assign pc_en        = w_fetch_rdy | r_ctl.jump | (r_state == S_EX_BR && w_taken && !w_br_bad);
    assign trap         = r_trap;
    assign trap_cause   = r_cause;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_instret;

    // Cycles outside TRAP and completed instructions (each return to FETCH)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            if (r_state != S_TRAP)
                r_cycle <= r_cycle + 1'b1;
            if (w_next == S_FETCH && r_state != S_FETCH)
                r_instret <= r_instret + 1'b1;
        end
    end

    assign cycle_cnt   = r_cycle;
    assign instret_cnt = r_instret;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller driven by directed instruction sequences.
module tb_mc_controller;
    localparam int CNT_W = 32;
`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic       pc_en;
        logic       adr_src;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] alu_op;
        logic [1:0] res;
        logic [2:0] imm;
        logic       trap;
        logic [1:0] cause;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] func3 = '0;
    logic [6:0] func7 = '0;
    logic zero = 1'b0, lt_s = 1'b0, lt_u = 1'b0, mem_ready = 1'b0;
    logic mem_req, mem_write, mem_unsigned, pc_en, adr_src, ir_write, reg_write, trap;
    logic [1:0] mem_size, alu_src_a, alu_src_b, result_src, trap_cause;
    logic [3:0] alu_op;
    logic [2:0] imm_src;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    snap_t dut_s;
    snap_t q_e[$];
    string q_n[$];
    int total = 0;
    int bad = 0;

    mc_controller #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func7(func7), .zero(zero),
        .lt_s(lt_s), .lt_u(lt_u), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .pc_en(pc_en), .adr_src(adr_src), .ir_write(ir_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .trap(trap), .trap_cause(trap_cause),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    assign dut_s = {mem_req, mem_write, mem_size, mem_unsigned, pc_en, adr_src, ir_write,
                    reg_write, alu_src_a, alu_src_b, alu_op, result_src, imm_src, trap, trap_cause};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    // Monitor: each mid-cycle, compare outputs against the oldest expected snapshot
    always @(negedge clk) begin
        if (q_e.size() > 0) begin
            snap_t e;
            string n;
            e = q_e.pop_front();
            n = q_n.pop_front();
            total++;
            if (dut_s !== e) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", n, dut_s, e);
            end
        end
    end

    function automatic snap_t s_fetch(input logic rdy);
        snap_t s = '0;
        s.mem_req = 1'b1; s.b = 2'b10; s.res = 2'b01; s.ir_write = rdy; s.pc_en = rdy;
        return s;
    endfunction
    function automatic snap_t s_dec();
        snap_t s = '0;
        s.a = 2'b01; s.b = 2'b01; s.imm = 3'd2;
        return s;
    endfunction
    function automatic snap_t s_ex(input logic is_i, input logic [3:0] aop);
        snap_t s = '0;
        s.a = 2'b10; s.b = is_i ? 2'b01 : 2'b00; s.alu_op = aop;
        return s;
    endfunction
    function automatic snap_t s_adr(input logic st);
        snap_t s = '0;
        s.a = 2'b10; s.b = 2'b01; s.imm = st ? 3'd1 : 3'd0;
        return s;
    endfunction
    function automatic snap_t s_mem(input logic wr, input logic [1:0] sz, input logic uns);
        snap_t s = '0;
        s.mem_req = 1'b1; s.mem_write = wr; s.mem_size = sz; s.mem_unsigned = uns; s.adr_src = 1'b1;
        return s;
    endfunction
    function automatic snap_t s_wb(input logic from_mem);
        snap_t s = '0;
        s.reg_write = 1'b1; s.res = from_mem ? 2'b10 : 2'b00;
        return s;
    endfunction
    function automatic snap_t s_br(input logic taken);
        snap_t s = '0;
        s.a = 2'b10; s.alu_op = 4'd1; s.pc_en = taken;
        return s;
    endfunction
    function automatic snap_t s_link();
        snap_t s = '0;
        s.a = 2'b01; s.b = 2'b10; s.res = 2'b01; s.reg_write = 1'b1;
        return s;
    endfunction
    function automatic snap_t s_jump(input logic jalr);
        snap_t s = '0;
        s.a = jalr ? 2'b10 : 2'b01; s.b = 2'b01; s.imm = jalr ? 3'd0 : 3'd3; s.res = 2'b01; s.pc_en = 1'b1;
        return s;
    endfunction
    function automatic snap_t s_lui();
        snap_t s = '0;
        s.imm = 3'd4; s.res = 2'b11; s.reg_write = 1'b1;
        return s;
    endfunction
    function automatic snap_t s_auipc();
        snap_t s = '0;
        s.a = 2'b01; s.b = 2'b01; s.imm = 3'd4;
        return s;
    endfunction
    function automatic snap_t s_trap(input logic [1:0] c);
        snap_t s = '0;
        s.trap = 1'b1; s.cause = c;
        return s;
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", n, got, want);
        end
    endtask

    task automatic step(input logic rdy, input snap_t e, input string n);
        q_e.push_back(e);
        q_n.push_back(n);
        mem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        op = o; func3 = f3; func7 = f7;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_drops_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_no_ir_write", {31'd0, ir_write}, 32'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_trap", {29'd0, trap, trap_cause}, 32'd0);
        chk("rst_fetch_moore", {27'd0, mem_req, alu_src_b, result_src}, {27'd0, 1'b1, 2'b10, 2'b01});
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_instret_cnt", instret_cnt, 32'd0);
    endtask

    task automatic run_alu(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [3:0] aop, input string n);
        set_ir(o, f3, f7);
        step(1'b1, s_fetch(1'b1), {n, "_fetch"});
        step(1'b1, s_dec(), {n, "_decode"});
        step(1'b1, s_ex(o == OP_I, aop), {n, "_ex"});
        step(1'b1, s_wb(1'b0), {n, "_wb"});
    endtask

    task automatic run_br(input logic [2:0] f3, input logic z, input logic ls, input logic lu,
                          input logic taken, input string n);
        set_ir(OP_BR, f3, 7'd0);
        zero = z; lt_s = ls; lt_u = lu;
        step(1'b1, s_fetch(1'b1), {n, "_fetch"});
        step(1'b1, s_dec(), {n, "_decode"});
        step(1'b1, s_br(taken), {n, "_exbr"});
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 3; i++) run_alu(OP_I, 3'b000, 7'd0, 4'd0, "addi");
        chk("perf_cycle_cnt", cycle_cnt, PERF ? 32'd12 : 32'd0);
        chk("perf_instret_cnt", instret_cnt, PERF ? 32'd3 : 32'd0);

        run_alu(OP_R, 3'b000, 7'd0, 4'd0, "add");
        run_alu(OP_I, 3'b101, 7'b0100000, 4'd9, "srai");
        run_alu(OP_R, 3'b000, 7'b0100000, 4'd1, "sub");
        run_alu(OP_R, 3'b011, 7'd0, 4'd5, "sltu");
        run_alu(OP_I, 3'b110, 7'b1010101, 4'd3, "ori");

        set_ir(OP_LD, 3'b010, 7'd0);
        step(1'b1, s_fetch(1'b1), "lw_fetch");
        step(1'b1, s_dec(), "lw_decode");
        step(1'b1, s_adr(1'b0), "lw_adr");
        for (int i = 0; i < 3; i++) step(1'b0, s_mem(1'b0, 2'b10, 1'b0), "lw_wait");
        step(1'b1, s_mem(1'b0, 2'b10, 1'b0), "lw_last_allowed");
        step(1'b1, s_wb(1'b1), "lw_wbmem");

        set_ir(OP_LD, 3'b100, 7'd0);
        step(1'b1, s_fetch(1'b1), "lbu_fetch");
        step(1'b1, s_dec(), "lbu_decode");
        step(1'b1, s_adr(1'b0), "lbu_adr");
        step(1'b1, s_mem(1'b0, 2'b00, 1'b1), "lbu_mem");
        step(1'b1, s_wb(1'b1), "lbu_wbmem");

        set_ir(OP_ST, 3'b001, 7'd0);
        step(1'b1, s_fetch(1'b1), "sh_fetch");
        step(1'b1, s_dec(), "sh_decode");
        step(1'b1, s_adr(1'b1), "sh_adr");
        step(1'b1, s_mem(1'b1, 2'b01, 1'b0), "sh_memwr");

        run_br(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, "bne_taken");
        run_br(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, "bne_not");
        run_br(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, "bgeu_not");
        run_br(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, "blt_taken");
        run_br(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, "beq_taken");

        set_ir(OP_JAL, 3'b000, 7'd0);
        step(1'b1, s_fetch(1'b1), "jal_fetch");
        step(1'b1, s_dec(), "jal_decode");
        step(1'b1, s_link(), "jal_link");
        step(1'b1, s_jump(1'b0), "jal_jump");

        set_ir(OP_JALR, 3'b000, 7'd0);
        step(1'b1, s_fetch(1'b1), "jalr_fetch");
        step(1'b1, s_dec(), "jalr_decode");
        step(1'b1, s_link(), "jalr_link");
        step(1'b1, s_jump(1'b1), "jalr_jump");

        set_ir(OP_LUI, 3'b000, 7'd0);
        step(1'b1, s_fetch(1'b1), "lui_fetch");
        step(1'b1, s_dec(), "lui_decode");
        step(1'b1, s_lui(), "lui_wb");

        set_ir(OP_AUIPC, 3'b000, 7'd0);
        step(1'b1, s_fetch(1'b1), "auipc_fetch");
        step(1'b1, s_dec(), "auipc_decode");
        step(1'b1, s_auipc(), "auipc_ex");
        step(1'b1, s_wb(1'b0), "auipc_wb");

        set_ir(OP_BR, 3'b010, 7'd0);
        step(1'b1, s_fetch(1'b1), "badbr_fetch");
        step(1'b1, s_dec(), "badbr_decode");
        step(1'b1, s_br(1'b0), "badbr_ex");
        step(1'b1, s_trap(2'b01), "badbr_trap");
        step(1'b1, s_trap(2'b01), "badbr_trap_hold");

        do_reset();
        set_ir(7'h7F, 3'b000, 7'd0);
        step(1'b1, s_fetch(1'b1), "illop_fetch");
        step(1'b1, s_dec(), "illop_decode");
        step(1'b1, s_trap(2'b01), "illop_trap");
        step(1'b1, s_trap(2'b01), "illop_trap_hold");

        do_reset();
        set_ir(OP_R, 3'b000, 7'd0);
        for (int i = 0; i < 4; i++) step(1'b0, s_fetch(1'b0), "timeout_wait");
        for (int i = 0; i < 3; i++) step(1'b1, s_trap(2'b10), "timeout_trap_sticky");

        do_reset();
        step(1'b1, s_fetch(1'b1), "post_trap_fetch");
        step(1'b1, s_dec(), "post_trap_decode");

        chk("scoreboard_drained", q_e.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
# mc_controller

Parametrised multicycle RV32I control FSM; successor to the single-handshake controller. Drives the shared-memory multicycle datapath (PC, IR, old-PC, A/B, ALU-out, MDR registers) with one-hot-free encoded control words. Adds memory wait-state handshake with timeout, full branch resolution, shifts, sub-word load/store qualifiers, a sticky trap state and optional performance counters.

## Interface

- WAIT_MAX, 15: max cycles mem_req may stay unanswered before trap; 0 disables timeout.
- CNT_W, 32: width of performance counters.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  IR[6:0]
- func3  in  3  IR[14:12]
- func7  in  7  IR[31:25]
- zero  in  1  ALU result == 0
- lt_s  in  1  signed rs1 < rs2 (ALU compare)
- lt_u  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access in progress
- mem_write  out  1  request is a write
- mem_size  out  2  00 byte, 01 half, 10 word
- mem_unsigned  out  1  zero-extend load
- pc_en, adr_src, ir_write, reg_write  out  1 each  register/mux enables (adr_src 0 PC, 1 ALU-out)
- alu_src_a  out  2  00 PC, 01 old PC, 10 A
- alu_src_b  out  2  00 B, 01 imm, 10 const 4
- alu_op  out  4  0 add,1 sub,2 and,3 or,4 slt,5 sltu,6 xor,7 sll,8 srl,9 sra
- result_src  out  2  00 ALU-out reg, 01 ALU, 10 MDR, 11 imm
- imm_src  out  3  0 I,1 S,2 B,3 J,4 U
- trap  out  1  sticky fault
- trap_cause  out  2  00 none, 01 illegal instr, 10 memory timeout
- cycle_cnt, instret_cnt  out  CNT_W each  performance counters

## Operation

- States: FETCH, DECODE, EX_R, EX_I, EX_ADR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, EX_BR, LINK, JUMP, WB_LUI, EX_AUIPC, TRAP.
- FETCH: mem_req, adr_src=0, a=PC, b=4, add, result_src=01; ir_write and pc_en asserted only in the mem_ready cycle; then DECODE.
- DECODE: a=old PC, b=imm(B), add (branch target to ALU-out). Dispatch by op: 0110011 EX_R, 0010011 EX_I, 0000011/0100011 EX_ADR, 1100011 EX_BR, 1101111/1100111 LINK, 0110111 WB_LUI, 0010111 EX_AUIPC; anything else TRAP (cause 01).
- EX_R: a=A, b=B, alu_op from func3/func7 (func7 0100000 legal only with func3 000 sub, 101 sra; other func7 != 0 → TRAP 01). EX_I: b=imm(I), same decode; slli/srli/srai check func7. Both → WB_ALU (reg_write, result_src=00) → FETCH.
- EX_ADR: a=A, b=imm(I load / S store), add → MEM_RD or MEM_WR. func3 outside {000,001,010,100,101} load / {000,001,010} store → TRAP 01.
- MEM_RD: mem_req, adr_src=1, size/unsigned from func3; hold until mem_ready → WB_MEM (result_src=10, reg_write) → FETCH. MEM_WR: additionally mem_write; on mem_ready → FETCH.
- EX_BR: a=A, b=B, sub; taken = beq zero, bne !zero, blt lt_s, bge !lt_s, bltu lt_u, bgeu !lt_u; pc_en=taken, result_src=00 → FETCH. func3 010/011 → TRAP 01.
- LINK: a=old PC, b=4, add, result_src=01, reg_write → JUMP. JUMP: jal a=old PC imm(J); jalr a=A imm(I); add, result_src=01, pc_en → FETCH. jalr bit-0 clear is the datapath's job.
- WB_LUI: imm(U), result_src=11, reg_write. EX_AUIPC: a=old PC, b=imm(U), add → WB_ALU.
- TRAP: all enables and mem_req 0; leaves only on reset.

## Timing

- Reset: state FETCH, all outputs 0 except fetch-state Moore values (mem_req=1, alu_src_b=10, result_src=01); trap=0, counters 0.
- Latency (zero wait): ALU 4, load 5, store 4, branch 3, jal/jalr 4, lui 3 cycles.
- Wait counter reloads on entry to each memory state; if it reaches WAIT_MAX without mem_ready → TRAP cause 10 next cycle. mem_ready on the final allowed cycle completes normally.
- mem_ready outside memory states is ignored. Reset mid-access drops mem_req asynchronously.

## Configuration

- MC_CTRL_PERF_EN defined: cycle_cnt increments every non-reset cycle outside TRAP; instret_cnt increments on every transition into FETCH from a non-FETCH state; both wrap at 2^CNT_W. Undefined: both ports tied to 0, no counter flops.

## Test plan

- add x3,x1,x2 (IR 0x002081B3), mem_ready always 1 → FETCH,DECODE,EX_R(alu_op 0),WB_ALU(reg_write) then FETCH; 4 cycles.
- lw with mem_ready delayed 3 cycles in MEM_RD → mem_req held 4 cycles, WB_MEM follows, mem_size=10.
- bne with zero=0 → pc_en=1 in EX_BR; with zero=1 → pc_en=0; bgeu lt_u=1 → not taken.
- WAIT_MAX=4, mem_ready held 0 in FETCH → trap=1, trap_cause=10 after 4 cycles; stays until rst_n low.
- opcode 0x7F → TRAP cause 01 after DECODE; srai with func7 0100000 executes alu_op 9.
- With MC_CTRL_PERF_EN, 3 back-to-back addi → instret_cnt=3, cycle_cnt=12.
